vga_plot_arbiter: RTL

- Shares the single `vga_adapter` pixel-write port (x, y, colour, plot) between NUM_REQ sprite engines (frog, car lanes, log lanes) on the 160x120, 3-bit-colour display.
- Each requester submits one rectangle command: origin, size, colour, draw/erase.
- The arbiter grants requesters round-robin and scans the granted rectangle one pixel per clock onto the VGA port.
- It sits between the sprite controllers and the `vga_adapter` instance, replacing direct plot wiring.

---
 rtl/frogger_vga_pkg.sv | 15 +
 rtl/rr_grant.sv | 47 ++++
 rtl/vga_plot_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/frogger_vga_pkg.sv
// Shared display constants and arbiter state encoding for the Frogger VGA path.
package frogger_vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;
endpackage

// File: rtl/rr_grant.sv
// Combinational requester selection: round-robin from ptr, or lowest index
// wins when VGA_ARB_FIXED_PRIO_EN is defined (no pointer port in that build).
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef VGA_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               valid
);

`ifdef VGA_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i]) begin
        valid     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    grant = valid ? (NUM_REQ'(1) << grant_idx) : '0;
  end
`else
  logic [IDX_W-1:0] cand;

  // Walk the ring starting at ptr; the first asserted request wins.
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        grant_idx = cand;
      end
    end
    grant = valid ? (NUM_REQ'(1) << grant_idx) : '0;
  end
`endif

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter pixel port between sprite engines, scanning one box
// pixel per clock. Define VGA_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches one command
// SCAN   | driving one box pixel per clock, row-major
// FINISH | first cycle pulses done, second cycle returns to IDLE
module vga_plot_arbiter
  import frogger_vga_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SZ_BITS = 4
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*X_W-1:0]      cmd_x,
  input  logic [NUM_REQ*Y_W-1:0]      cmd_y,
  input  logic [NUM_REQ*SZ_BITS-1:0]  cmd_w,
  input  logic [NUM_REQ*SZ_BITS-1:0]  cmd_h,
  input  logic [NUM_REQ*COLOUR_W-1:0] cmd_colour,
  input  logic [NUM_REQ-1:0]          cmd_erase,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic [X_W-1:0]              vga_x,
  output logic [Y_W-1:0]              vga_y,
  output logic [COLOUR_W-1:0]         vga_colour,
  output logic                        vga_plot
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              state;
  logic [IDX_W-1:0]    gidx;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [SZ_BITS-1:0]  w, h, cx, cy;
  logic [COLOUR_W-1:0] colour;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;

  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  logic                on_screen;

`ifndef VGA_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]    ptr;
`endif

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_grant (
    .req       (req),
`ifndef VGA_ARB_FIXED_PRIO_EN
    .ptr       (ptr),
`endif
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  // One extra bit on each sum so off-screen pixels are detected, not wrapped.
  assign sum_x     = {1'b0, x0} + (X_W+1)'(cx);
  assign sum_y     = {1'b0, y0} + (Y_W+1)'(cy);
  assign on_screen = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      gidx       <= '0;
      x0         <= '0;
      y0         <= '0;
      w          <= '0;
      h          <= '0;
      cx         <= '0;
      cy         <= '0;
      colour     <= '0;
      ack        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
`ifndef VGA_ARB_FIXED_PRIO_EN
      ptr        <= '0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          done     <= '0;
          vga_plot <= 1'b0;
          if (grant_valid) begin
            gidx   <= grant_idx;
            x0     <= cmd_x[grant_idx*X_W +: X_W];
            y0     <= cmd_y[grant_idx*Y_W +: Y_W];
            w      <= cmd_w[grant_idx*SZ_BITS +: SZ_BITS];
            h      <= cmd_h[grant_idx*SZ_BITS +: SZ_BITS];
            colour <= cmd_erase[grant_idx] ? COLOUR_BLACK
                                           : cmd_colour[grant_idx*COLOUR_W +: COLOUR_W];
            cx     <= '0;
            cy     <= '0;
            ack    <= grant;
            busy   <= 1'b1;
            state  <= SCAN;
`ifndef VGA_ARB_FIXED_PRIO_EN
            ptr    <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
`endif
          end
        end
        SCAN: begin
          vga_x      <= sum_x[X_W-1:0];
          vga_y      <= sum_y[Y_W-1:0];
          vga_colour <= colour;
          vga_plot   <= on_screen;
          if (cx == w) begin
            cx <= '0;
            if (cy == h) state <= FINISH;
            else         cy    <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        FINISH: begin
          vga_plot <= 1'b0;
          if (done == '0) begin
            done <= NUM_REQ'(1) << gidx;
          end else begin
            done  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
